// File: rtl/mont_domain_conv.sv
// Montgomery domain converter.
// dir=0 computes X*R mod N by Montgomery-multiplying X with R^2 mod N.
// dir=1 computes X*R^-1 mod N by Montgomery-multiplying X with 1.
// A bit-serial radix-2 Montgomery product runs for DATA_LENGTH cycles.
// One conditional-subtract cycle follows, then a registered done pulse.
module mont_domain_conv #(
  parameter int DATA_LENGTH = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dir,
  input  logic [DATA_LENGTH-1:0] X,
  input  logic [DATA_LENGTH-1:0] N,
  input  logic [DATA_LENGTH:0]   R2,
  output logic [DATA_LENGTH-1:0] Y,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  // Two spare bits keep A + B + N (all below 2N) from overflowing.
  localparam int AW = DATA_LENGTH + 2;

  typedef enum logic [1:0] {IDLE, ITER, CORR} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic [AW-1:0]          a;
  logic [DATA_LENGTH-1:0] x_sh;
  logic [DATA_LENGTH-1:0] n_r;
  logic [DATA_LENGTH-1:0] b_r;

  logic                   accept, reject, finish;
  logic [DATA_LENGTH-1:0] b_load;
  logic [AW-1:0]          b_ext, n_ext, sum, sum_odd, a_step;
  logic [DATA_LENGTH-1:0] y_corr;

  // R^2 mod N is below N, so its top bit is always zero and is not used.
  logic r2_msb_unused;
  assign r2_msb_unused = R2[DATA_LENGTH];

  // Multiplicand selected at acceptance: R^2 mod N enters the domain, 1 leaves it.
  assign b_load = dir ? DATA_LENGTH'(1) : R2[DATA_LENGTH-1:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        // A start arriving while done is still high is ignored.
        if (start && !done) begin
          if (N[0]) begin
            accept     = 1'b1;
            state_next = ITER;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ITER: begin
        if (cnt == '0) state_next = CORR;
      end
      CORR: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One Montgomery step (add X[i]*B, make even with N, halve) and the final subtract.
  always_comb begin
    b_ext   = {2'b00, b_r};
    n_ext   = {2'b00, n_r};
    sum     = a + (x_sh[0] ? b_ext : '0);
    sum_odd = sum[0] ? sum + n_ext : sum;
    a_step  = sum_odd >> 1;
    y_corr  = (a >= n_ext) ? DATA_LENGTH'(a - n_ext) : a[DATA_LENGTH-1:0];
  end

  // Datapath registers, result register and status flags.
  // NOTE: these are plain flops, not a memory, so all are cleared by reset; an abort leaves Y at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a    <= '0;
      x_sh <= '0;
      n_r  <= '0;
      b_r  <= '0;
      Y    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= finish;
      err  <= reject;
      if (accept) begin
        x_sh <= X;
        n_r  <= N;
        b_r  <= b_load;
        a    <= '0;
        cnt  <= CW'(DATA_LENGTH - 1);
        busy <= 1'b1;
      end else if (state == ITER) begin
        a    <= a_step;
        x_sh <= x_sh >> 1;
        if (cnt != '0) cnt <= cnt - CW'(1);
      end else if (finish) begin
        Y    <= y_corr;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mont_domain_conv.sv
// Scoreboard bench for mont_domain_conv with DATA_LENGTH=8, N=13.
// R mod N = 9, R^2 mod N = 3, R^-1 mod N = 3.
module tb_mont_domain_conv;

  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [DL-1:0] xin = '0;
  logic [DL-1:0] nin = 8'd13;
  logic [DL:0]   r2 = 9'd3;
  logic [DL-1:0] y;
  logic          busy, done, err;

  mont_domain_conv #(.DATA_LENGTH(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .X     (xin),
    .N     (nin),
    .R2    (r2),
    .Y     (y),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DL-1:0] y;
    int            due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int exp_dones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each done against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("exclusive_flags", 32'(busy) + 32'(done) + 32'(err) <= 1, 1);
      if (err) err_seen++;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: Y=%0d with no request pending (cycle %0d)", y, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("Y", 32'(y), 32'(e.y));
          check("latency", cyc, e.due);
          check("busy_at_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Issues one request, then scrambles the inputs to prove they were captured.
  task automatic run(input logic d, input logic [DL-1:0] x, input logic [DL-1:0] ey);
    @(negedge clk);
    dir   = d;
    xin   = x;
    start = 1'b1;
    sb.push_back('{ey, cyc + 10});
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    xin = ~x;
    dir = ~d;
    drain();
  endtask

  int base;

  initial begin
    #23;
    check("reset_Y", 32'(y), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    rst_n = 1'b1;

    // Forward, inverse and round trips.
    run(1'b0, 8'd5, 8'd6);
    run(1'b1, 8'd6, 8'd5);
    run(1'b0, 8'd12, 8'd4);
    run(1'b1, 8'd4, 8'd12);
    // Boundaries.
    run(1'b0, 8'd0, 8'd0);
    run(1'b0, 8'd1, 8'd9);
    run(1'b1, 8'd9, 8'd1);

    // Even modulus is rejected with a single err pulse; Y keeps its value.
    @(negedge clk);
    nin   = 8'd12;
    dir   = 1'b0;
    xin   = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 1);
    check("reject_busy", 32'(busy), 0);
    @(negedge clk);
    check("err_one_cycle", 32'(err), 0);
    check("reject_busy_later", 32'(busy), 0);
    check("reject_Y_kept", 32'(y), 1);
    nin = 8'd13;

    // Start during busy is ignored, even with changed operands and an even modulus.
    @(negedge clk);
    dir   = 1'b0;
    xin   = 8'd5;
    start = 1'b1;
    sb.push_back('{8'd6, cyc + 10});
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dir   = 1'b1;
    xin   = 8'd1;
    nin   = 8'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    nin = 8'd13;
    repeat (15) @(negedge clk);

    // Start held through the done cycle: ignored there, accepted one edge later.
    @(negedge clk);
    dir   = 1'b0;
    xin   = 8'd2;
    start = 1'b1;
    base  = cyc;
    sb.push_back('{8'd5, base + 10});
    exp_dones++;
    while (cyc < base + 11) @(negedge clk);
    check("done_cycle_start_ignored", 32'(busy), 0);
    sb.push_back('{8'd5, base + 21});
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
    check("accept_after_done", 32'(busy), 1);
    drain();

    // Reset during the fourth ITER cycle aborts the operation.
    @(negedge clk);
    dir   = 1'b0;
    xin   = 8'd5;
    start = 1'b1;
    base  = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_Y", 32'(y), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run(1'b0, 8'd5, 8'd6);

    repeat (5) @(negedge clk);
    check("done_count", done_seen, exp_dones);
    check("err_count", err_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_domain_conv.md
MONT_DOMAIN_CONV -- requirements
Module: mont_domain_conv

Parameters
REQ-001 DATA_LENGTH, 4096, modulus/operand width in bits; R = 2^DATA_LENGTH.

Interface
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dir  input  1  0 = into Montgomery domain (X*R mod N); 1 = out of it (X*R^-1 mod N).
REQ-006 X  input  DATA_LENGTH  operand; caller guarantees X < N.
REQ-007 N  input  DATA_LENGTH  modulus; must be odd.
REQ-008 R2  input  DATA_LENGTH+1  R^2 mod N, taken from the R_t output of the constants block; value < N, so bit DATA_LENGTH is 0 and is ignored.
REQ-009 Y  output  DATA_LENGTH  result register; holds its value until the next completion.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse; Y is valid in that cycle.
REQ-012 err  output  1  one-cycle pulse when start is rejected because N is even.

Function
REQ-013 States: IDLE, ITER, CORR. Encoding is free.
REQ-014 IDLE, start=1, N[0]=1: capture X, N, dir and B on the edge; go to ITER; load counter = DATA_LENGTH-1; clear A.
REQ-015 B = R2[DATA_LENGTH-1:0] when dir=0; B = 1 when dir=1.
REQ-016 IDLE, start=1, N[0]=0: assert err for one cycle; stay in IDLE; leave Y unchanged.
REQ-017 ITER does one radix-2 Montgomery step per cycle, with i = DATA_LENGTH-1-counter: A' = A + X[i]*B; if A' is odd, A' = A' + N; A = A'>>1.
REQ-018 A is DATA_LENGTH+2 bits wide; no intermediate overflow is permitted.
REQ-019 Bits of X are consumed LSB first; the captured X may be shifted in place.
REQ-020 ITER with counter = 0: perform the final step and go to CORR. Otherwise decrement the counter.
REQ-021 CORR: Y = (A >= N) ? A-N : A, truncated to DATA_LENGTH bits; done = 1 for that cycle; busy = 0; next state IDLE.
REQ-022 Latency: start sampled at edge k, so done is high after edge k+DATA_LENGTH+1. There are exactly DATA_LENGTH ITER cycles.
REQ-023 start while busy is ignored; no queuing.
REQ-024 start in the done cycle is ignored. The earliest next acceptance is the following edge.
REQ-025 Changes to X, N, R2 or dir after acceptance do not affect the running operation.
REQ-026 Results:
- dir=0 gives Y = X*R mod N.
- dir=1 gives Y = X*R^-1 mod N.
- X = 0 gives Y = 0 in both directions.
REQ-027 busy, done and err are never high in the same cycle.

Reset
REQ-028 With rst_n low, asynchronously:
- state = IDLE
- Y = 0, busy = 0, done = 0, err = 0
- A, counter and captured operands = 0
REQ-029 Reset mid-operation aborts the operation: no done, and Y = 0.
REQ-030 After rst_n rises, the first start is accepted on the first posedge.

Verification (DATA_LENGTH = 8, N = 13, R mod N = 9, R2 = 3)
REQ-031 Forward conversion: start with dir=0, X=5 -> busy high for 8 ITER cycles, done 9 cycles after the start edge, Y = 6.
REQ-032 Inverse and round trip: start with dir=1, X=6 -> Y = 5. Run dir=0 with X=12 -> Y = 4, then dir=1 with X=4 -> Y = 12.
REQ-033 Boundaries: dir=0 with X=0 -> Y = 0. dir=0 with X=1 -> Y = 9 (R mod N). dir=1 with X=9 -> Y = 1.
REQ-034 Rejection: start with N=12 -> err pulse of one cycle, busy stays 0, Y unchanged. A second start pulsed during busy is ignored, and there is exactly one done per accepted start.
REQ-035 Reset mid-operation: drop rst_n during the 4th ITER cycle -> Y = 0, busy = 0, and no done appears. A new start with dir=0, X=5 -> Y = 6 at the correct latency.
REQ-036 Full-width check: DATA_LENGTH = 4096, random odd N, R2 from a reference model -> a dir=0 then dir=1 round trip returns the original X, and done arrives 4097 cycles after start.
